complex_result_fifo: RTL and testbench
======================================

Name: complex_result_fifo

Overview:
Output buffer that sits directly downstream of the complex number multiplier. It accepts product pairs (result_re, result_im) over the multiplier's res_val/res_ready handshake and stores them in a first-word-fall-through FIFO. It then presents them to the consumer over an out_val/out_ready handshake. This decouples multiplier throughput from sink back-pressure and lets the multiplier keep issuing while the consumer stalls.

Parameters:
DATA_WIDTH, 8, operand width of the multiplier; each stored component is 2*DATA_WIDTH bits
DEPTH, 4, number of entries; must be a power of two and at least 2
ADDR_WIDTH, clog2(DEPTH), pointer index width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
sw_rst  input  1  synchronous flush, active-high
in_val  input  1  product valid; connects to multiplier res_val
in_ready  output  1  FIFO can accept; connects to multiplier res_ready
in_re  input  2*DATA_WIDTH  product real part
in_im  input  2*DATA_WIDTH  product imaginary part
out_val  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_re  output  2*DATA_WIDTH  head real part
out_im  output  2*DATA_WIDTH  head imaginary part
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values (rst asserted): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, in_ready=1, out_val=0, out_re=0, out_im=0. Storage array is not reset.
- in_ready = !full and out_val = !empty. Both are derived combinationally from the registered count.
- Push occurs when in_val && in_ready. The entry is written at wr_ptr on the clock edge, then wr_ptr increments modulo DEPTH.
- Pop occurs when out_val && out_ready. rd_ptr increments modulo DEPTH on the clock edge.
- FWFT output: out_re/out_im show mem[rd_ptr] whenever !empty, and are forced to 0 while empty.
- Latency: a push into an empty FIFO gives out_val=1 on the cycle after the push edge. There is no same-cycle bypass.
- count update rules:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
- Full boundary: in_ready=0, so no push occurs even if out_ready=1 in the same cycle. The pop still proceeds, and in_ready returns on the next cycle.
- Empty boundary: out_val=0, so no pop occurs. out_ready is ignored.
- Pointer wrap: a pointer at DEPTH-1 returns to 0. After the first wrap, count alone distinguishes full from empty when wr_ptr == rd_ptr.
- sw_rst (synchronous) has priority over push and pop. On the next edge, pointers and count clear to 0; any push or pop in that same cycle is discarded. in_ready remains combinationally !full throughout.
- rst mid-operation: immediate asynchronous clear as in the reset-values list; stored data is lost logically.
- in_re/in_im must be stable while in_val=1 and in_ready=0. The FIFO does not sample data outside a push cycle.
- No overflow or underflow is possible by construction. The bench shall flag any push while full or pop while empty as a protocol error.

Decomposition:
- Shared package, complex_mult_pkg: DATA_WIDTH default constant, a clog2 function, and result-width constant RES_WIDTH = 2*DATA_WIDTH. The multiplier and the monitor reuse these.
- One sub-module, complex_fifo_mem: a DEPTH x (2*RES_WIDTH) register array with one synchronous write port and one asynchronous read port.
- Pointer, count and handshake control live in complex_result_fifo itself.

Test Plan:
- Single pass: rst, then push (re=0x0012, im=0xFFF6) with out_ready=1 -> out_val=1 on the next cycle with the same data; count goes 1 then 0; empty re-asserts.
- Fill to full: DEPTH=4, out_ready=0, push 0x0001..0x0004 (im = re+0x0100) -> full=1, in_ready=0, count=4. A fifth in_val is not accepted. Draining yields 0x0001..0x0004 in order.
- Simultaneous push/pop:
  - At count=2, push and pop in one cycle -> count stays 2; the correct head advances.
  - At full, in_val=1 and out_ready=1 -> only the pop happens; count=3 next cycle.
- Wrap-around: 10 pushes interleaved with pops (max occupancy 3), values 0x00A0+i -> output order matches input order exactly across two pointer wraps.
- Flush: count=3, assert sw_rst with in_val=1 and out_ready=1 -> next cycle count=0, empty=1, out_re=out_im=0. The pushed value never appears.
- Async reset mid-stream: assert rst between clock edges at count=2 -> count=0, out_val=0 immediately. After release, the first push is the first item out.
- End-to-end with multiplier: (3+4j)*(2-1j), DATA_WIDTH=8 -> FIFO outputs re=10 (0x000A), im=5 (0x0005). Under random out_ready, the monitor sees no lost or duplicated results.

Source files
------------

// File: rtl/complex_mult_pkg.sv
`default_nettype none
// ============================================================================
// complex_mult_pkg : widths and helpers shared by the complex multiplier path
// Revision 1.0
// ============================================================================
package complex_mult_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int RES_WIDTH          = 2 * DEFAULT_DATA_WIDTH;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_fifo_mem.sv
`default_nettype none
// ============================================================================
// complex_fifo_mem : register array, one synchronous write, one async read
// Revision 1.0
// ============================================================================
module complex_fifo_mem
    import complex_mult_pkg::*;
#(
    parameter int WIDTH = 2 * RES_WIDTH,
    parameter int DEPTH = 4,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/complex_result_fifo.sv
`default_nettype none
// ============================================================================
// complex_result_fifo : FWFT buffer between complex multiplier and consumer
// Revision 1.0
// ============================================================================
module complex_result_fifo
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_rst,
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_re,
    input  logic [2*DATA_WIDTH-1:0] in_im,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_re,
    output logic [2*DATA_WIDTH-1:0] out_im,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    full,
    output logic                    empty
);

    localparam int                  COMP_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [2*COMP_WIDTH-1:0] head;
    logic                    push;
    logic                    pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign out_val  = !empty;
    assign push     = in_val && in_ready;
    assign pop      = out_val && out_ready;

    // Empty entries read as zero so stale storage never leaks to the sink.
    assign out_re = empty ? '0 : head[2*COMP_WIDTH-1:COMP_WIDTH];
    assign out_im = empty ? '0 : head[COMP_WIDTH-1:0];

    complex_fifo_mem #(
        .WIDTH (2 * COMP_WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !sw_rst),
        .waddr (wr_ptr),
        .wdata ({in_re, in_im}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_result_fifo.sv
`default_nettype none
// ============================================================================
// tb_complex_result_fifo : directed checks plus a queue scoreboard on the FIFO
// Revision 1.0
// ============================================================================
module tb_complex_result_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 4;
    localparam int CW         = 2 * DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_rst = 1'b0;
    logic          in_val = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_re = '0;
    logic [CW-1:0] in_im = '0;
    logic          out_val;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_re;
    logic [CW-1:0] out_im;
    logic [2:0]    count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb_q [$];
    int          sb_pops = 0;

    complex_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst    (sw_rst),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_val   (out_val),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [CW-1:0] re, input logic [CW-1:0] im);
        in_val = 1'b1;
        in_re  = re;
        in_im  = im;
        step();
        in_val = 1'b0;
    endtask

    function automatic logic [31:0] cmul(input logic signed [7:0] ar, input logic signed [7:0] ai,
                                         input logic signed [7:0] br, input logic signed [7:0] bi);
        logic signed [15:0] re;
        logic signed [15:0] im;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    // Reference queue: handshake, occupancy-bound and ordering checks at every edge.
    always @(posedge clk) begin
        if (!rst) begin
            check("sb_in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < DEPTH});
            check("sb_out_val", {31'd0, out_val}, {31'd0, sb_q.size() > 0});
            if (sw_rst) begin
                sb_q.delete();
            end else begin
                if (out_ready && sb_q.size() > 0) begin
                    check("sb_data", {out_re, out_im}, sb_q[0]);
                    void'(sb_q.pop_front());
                    sb_pops = sb_pops + 1;
                end
                if (in_val && in_ready && sb_q.size() < DEPTH) begin
                    sb_q.push_back({in_re, in_im});
                end
            end
        end
    end

    always @(posedge rst) sb_q.delete();

    initial begin
        int k;
        int sent;
        int cyc;
        logic [7:0] ops [4];

        #1;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_val", {31'd0, out_val}, 32'd0);
        check("rst_out_data", {out_re, out_im}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // single pass with consumer ready
        out_ready = 1'b1;
        push_one(16'h0012, 16'hFFF6);
        check("pass_val", {31'd0, out_val}, 32'd1);
        check("pass_data", {out_re, out_im}, 32'h0012_FFF6);
        check("pass_count1", {29'd0, count}, 32'd1);
        step();
        check("pass_count0", {29'd0, count}, 32'd0);
        check("pass_empty", {31'd0, empty}, 32'd1);

        // fill to full with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_one(16'(i), 16'(i + 'h100));
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        check("fill_count", {29'd0, count}, 32'd4);
        push_one(16'h0005, 16'h0105);
        check("fill_reject", {29'd0, count}, 32'd4);

        // at full, push and pop together: only the pop happens
        in_val = 1'b1;
        in_re = 16'h0005;
        in_im = 16'h0105;
        out_ready = 1'b1;
        check("full_head", {out_re, out_im}, 32'h0001_0101);
        step();
        in_val = 1'b0;
        check("full_pop_count", {29'd0, count}, 32'd3);
        check("full_pop_ready", {31'd0, in_ready}, 32'd1);
        for (int j = 2; j <= 4; j++) begin
            check("drain_order", {out_re, out_im}, {16'(j), 16'(j + 'h100)});
            step();
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        out_ready = 1'b0;

        // push and pop in one cycle at count 2
        push_one(16'h0021, 16'h0121);
        push_one(16'h0022, 16'h0122);
        in_val = 1'b1;
        in_re = 16'h0023;
        in_im = 16'h0123;
        out_ready = 1'b1;
        check("pp_head0", {out_re, out_im}, 32'h0021_0121);
        step();
        in_val = 1'b0;
        check("pp_count", {29'd0, count}, 32'd2);
        check("pp_head1", {out_re, out_im}, 32'h0022_0122);
        step();
        check("pp_head2", {out_re, out_im}, 32'h0023_0123);
        step();
        check("pp_empty", {31'd0, empty}, 32'd1);
        out_ready = 1'b0;

        // wrap-around: 3 fill, 7 steady push+pop, 3 drain
        k = 0;
        for (int c = 0; c < 13; c++) begin
            in_val = (c < 10);
            in_re = 16'(16'h00A0 + c);
            in_im = 16'(16'h01A0 + c);
            out_ready = (c >= 3);
            if (out_val && out_ready) begin
                check("wrap_order", {out_re, out_im}, {16'(16'h00A0 + k), 16'(16'h01A0 + k)});
                k = k + 1;
            end
            step();
        end
        in_val = 1'b0;
        out_ready = 1'b0;
        check("wrap_total", k, 32'd10);
        check("wrap_empty", {31'd0, empty}, 32'd1);

        // flush discards the same-cycle push and pop
        push_one(16'h00B0, 16'h01B0);
        push_one(16'h00B1, 16'h01B1);
        push_one(16'h00B2, 16'h01B2);
        in_val = 1'b1;
        in_re = 16'h00BB;
        in_im = 16'h01BB;
        out_ready = 1'b1;
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        in_val = 1'b0;
        out_ready = 1'b0;
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_data", {out_re, out_im}, 32'd0);
        push_one(16'h00C0, 16'h01C0);
        check("flush_next", {out_re, out_im}, 32'h00C0_01C0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("flush_drained", {31'd0, empty}, 32'd1);

        // asynchronous reset between edges
        push_one(16'h00D0, 16'h01D0);
        push_one(16'h00D1, 16'h01D1);
        check("arst_pre", {29'd0, count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_out_val", {31'd0, out_val}, 32'd0);
        #1;
        rst = 1'b0;
        step();
        push_one(16'h00E0, 16'h01E0);
        check("arst_first", {out_re, out_im}, 32'h00E0_01E0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // multiplier product (3+4j)*(2-1j) = 10+5j
        {in_re, in_im} = cmul(8'sd3, 8'sd4, 8'sd2, -8'sd1);
        push_one(in_re, in_im);
        check("e2e_product", {out_re, out_im}, 32'h000A_0005);
        out_ready = 1'b1;
        step();

        // random products under random back-pressure
        sent = 0;
        cyc = 0;
        for (int i = 0; i < 4; i++) ops[i] = 8'($urandom);
        {in_re, in_im} = cmul(ops[0], ops[1], ops[2], ops[3]);
        while ((sent < 20 || !empty) && cyc < 400) begin
            logic accepted;
            in_val = (sent < 20);
            out_ready = 1'($urandom_range(0, 1));
            accepted = in_val && in_ready;
            step();
            cyc = cyc + 1;
            if (accepted) begin
                sent = sent + 1;
                for (int i = 0; i < 4; i++) ops[i] = 8'($urandom);
                {in_re, in_im} = cmul(ops[0], ops[1], ops[2], ops[3]);
            end
        end
        in_val = 1'b0;
        out_ready = 1'b0;
        check("rand_sent", sent, 32'd20);
        check("rand_drained", {31'd0, empty}, 32'd1);
        check("rand_model_empty", sb_q.size(), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
